// File: rtl/tt_um_prampal_serial_subtractor_if.sv
// TinyTapeout tile pin bundle: dedicated inputs, outputs and the bidirectional bank.
// The harness drives through master; the tile sits on slave.
interface tt_um_prampal_serial_subtractor_if;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       ena;

    modport master (
        output ui_in, uio_in, ena,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ui_in, uio_in, ena,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/tt_um_prampal_serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor D = A - B with registered borrow and synchronised start.
// Results appear on uo_out only when an operation completes.
module tt_um_prampal_serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    tt_um_prampal_serial_subtractor_if.slave io
);
    localparam logic [3:0] MASK = 4'((5'd1 << WIDTH) - 5'd1);
    localparam logic [1:0] LAST = 2'(WIDTH - 1);
    localparam int         PAD  = 4 - WIDTH;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t     state_reg;
    logic       s1_reg, s2_reg, s3_reg;
    logic [3:0] a_reg, b_reg, res_reg, d_reg;
    logic [1:0] cnt_reg;
    logic       br_reg, borrow_reg, busy_reg, done_reg;

    logic       start_edge;
    logic       a0, b0, d_bit, br_next;
    logic [3:0] res_next;

    assign start_edge = s2_reg & ~s3_reg;
    assign a0         = a_reg[0];
    assign b0         = b_reg[0];
    assign d_bit      = a0 ^ b0 ^ br_reg;
    assign br_next    = (~a0 & b0) | (~(a0 ^ b0) & br_reg);
    assign res_next   = {d_bit, res_reg[3:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
            s3_reg <= 1'b0;
        end else begin
            s1_reg <= io.uio_in[0];
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            a_reg      <= 4'd0;
            b_reg      <= 4'd0;
            res_reg    <= 4'd0;
            d_reg      <= 4'd0;
            cnt_reg    <= 2'd0;
            br_reg     <= 1'b0;
            borrow_reg <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start_edge) begin
                        a_reg     <= io.ui_in[3:0] & MASK;
                        b_reg     <= io.ui_in[7:4] & MASK;
                        res_reg   <= 4'd0;
                        br_reg    <= 1'b0;
                        cnt_reg   <= 2'd0;
                        busy_reg  <= 1'b1;
                        done_reg  <= 1'b0;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_reg   <= a_reg >> 1;
                    b_reg   <= b_reg >> 1;
                    br_reg  <= br_next;
                    res_reg <= res_next;
                    cnt_reg <= cnt_reg + 2'd1;
                    // Result bits enter from bit 3; narrow widths are right-aligned on completion.
                    if (cnt_reg == LAST) begin
                        d_reg      <= res_next >> PAD;
                        borrow_reg <= br_next;
                        busy_reg   <= 1'b0;
                        done_reg   <= 1'b1;
                        state_reg  <= DONE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign io.uo_out  = {1'b0, done_reg, busy_reg, borrow_reg, d_reg};
    assign io.uio_out = 8'h00;
    assign io.uio_oe  = 8'h00;

    logic unused;
    assign unused = &{1'b0, io.ena, io.uio_in[7:1], io.ui_in};
endmodule
